// File: rtl/toggle_decoder_if.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : toggle_decoder_if
// Purpose  : Toggle input, event handshake and status bundle for toggle_decoder.
// Revision : 1.0
// ============================================================================
interface toggle_decoder_if #(
    parameter int CNT_W = 8
);
    logic             i_tog;
    logic             i_ready;
    logic             o_pulse;
    logic             o_valid;
    logic [CNT_W-1:0] o_pending;
    logic             o_overflow;
    logic             o_level;

    // master = the decoder, slave = transmitter line plus event consumer
    modport master (
        input  i_tog,
        input  i_ready,
        output o_pulse,
        output o_valid,
        output o_pending,
        output o_overflow,
        output o_level
    );

    modport slave (
        output i_tog,
        output i_ready,
        input  o_pulse,
        input  o_valid,
        input  o_pending,
        input  o_overflow,
        input  o_level
    );
endinterface
`default_nettype wire

// File: rtl/toggle_decoder.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : toggle_decoder
// Purpose  : Turns each level change on a toggle line into one event pulse and
//            a saturating pending count drained over valid/ready.
//            Optional macro TOGGLE_DEC_GLITCH_FILTER_EN: require a change to
//            persist two cycles before it is accepted.
// Revision : 1.0
// ============================================================================
module toggle_decoder #(
    parameter int SYNC_STAGES = 2,
    parameter int CNT_W       = 8
) (
    input  logic             clk,
    input  logic             reset,
    toggle_decoder_if.master bus
);
    localparam int                 c_ARM_W    = $clog2(SYNC_STAGES + 1);
    localparam logic [c_ARM_W-1:0] c_ARM_LAST = c_ARM_W'(SYNC_STAGES);
    localparam logic [CNT_W-1:0]   c_CNT_MAX  = '1;

    typedef enum logic [0:0] {
        ST_ARM = 1'b0,
        ST_RUN = 1'b1
    } state_t;

    state_t                 r_state;
    state_t                 w_state_next;
    logic [SYNC_STAGES-1:0] r_sync;
    logic                   r_prev;
    logic [c_ARM_W-1:0]     r_arm_cnt;
    logic                   r_pulse;
    logic                   r_overflow;
    logic [CNT_W-1:0]       r_pending;

    logic w_sync_out;
    logic w_diff;
    logic w_edge;
    logic w_valid;
    logic w_pop;
    logic w_full;

`ifdef TOGGLE_DEC_GLITCH_FILTER_EN
    logic r_diff_d;
`endif

    assign w_sync_out = r_sync[SYNC_STAGES-1];
    assign w_diff     = w_sync_out ^ r_prev;
    assign w_valid    = (r_pending != '0);
    assign w_pop      = w_valid & bus.i_ready;
    assign w_full     = (r_pending == c_CNT_MAX);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_sync <= '0;
        end else begin
            r_sync <= {r_sync[SYNC_STAGES-2:0], bus.i_tog};
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= ST_ARM;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        w_edge       = 1'b0;
        case (r_state)
            ST_ARM: begin
                if (r_arm_cnt == c_ARM_LAST) begin
                    w_state_next = ST_RUN;
                end
            end
            ST_RUN: begin
`ifdef TOGGLE_DEC_GLITCH_FILTER_EN
                w_edge = w_diff & r_diff_d;
`else
                w_edge = w_diff;
`endif
            end
            default: begin
                w_state_next = ST_ARM;
            end
        endcase
    end

    // Arm window lets the synchroniser fill so a line already high at reset
    // release is absorbed into r_prev instead of counted as an event.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_arm_cnt <= '0;
        end else if ((r_state == ST_ARM) && (r_arm_cnt != c_ARM_LAST)) begin
            r_arm_cnt <= r_arm_cnt + c_ARM_W'(1);
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_prev   <= 1'b0;
`ifdef TOGGLE_DEC_GLITCH_FILTER_EN
            r_diff_d <= 1'b0;
`endif
        end else begin
`ifdef TOGGLE_DEC_GLITCH_FILTER_EN
            if ((r_state == ST_ARM) || w_edge) begin
                r_prev <= w_sync_out;
            end
            r_diff_d <= (r_state == ST_RUN) & w_diff & ~w_edge;
`else
            r_prev <= w_sync_out;
`endif
        end
    end

    // Simultaneous edge and pop cancel out, so a full counter never overflows
    // on a cycle where the consumer takes an event.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_pulse    <= 1'b0;
            r_pending  <= '0;
            r_overflow <= 1'b0;
        end else begin
            r_pulse <= w_edge;
            case ({w_edge, w_pop})
                2'b10: begin
                    if (w_full) begin
                        r_overflow <= 1'b1;
                    end else begin
                        r_pending <= r_pending + CNT_W'(1);
                    end
                end
                2'b01: begin
                    r_pending <= r_pending - CNT_W'(1);
                end
                default: begin
                end
            endcase
        end
    end

    assign bus.o_pulse    = r_pulse;
    assign bus.o_valid    = w_valid;
    assign bus.o_pending  = r_pending;
    assign bus.o_overflow = r_overflow;
    assign bus.o_level    = w_sync_out;

endmodule
`default_nettype wire

// File: tb/tb_toggle_decoder.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : tb_toggle_decoder
// Purpose  : Directed vector bench; one 8-bit and one 2-bit counter instance
//            share the toggle line and reset.
// Revision : 1.0
// ============================================================================
module tb_toggle_decoder;
    localparam int SYNC_STAGES = 2;

    logic clk;
    logic reset;
    logic tog;
    logic rdy_a;
    logic rdy_b;
    int   n_vec;
    int   n_bad;

    toggle_decoder_if #(.CNT_W(8)) bus_a ();
    toggle_decoder_if #(.CNT_W(2)) bus_b ();

    assign bus_a.i_tog   = tog;
    assign bus_b.i_tog   = tog;
    assign bus_a.i_ready = rdy_a;
    assign bus_b.i_ready = rdy_b;

    toggle_decoder #(.SYNC_STAGES(SYNC_STAGES), .CNT_W(8)) u_dut_a (
        .clk   (clk),
        .reset (reset),
        .bus   (bus_a.master)
    );

    toggle_decoder #(.SYNC_STAGES(SYNC_STAGES), .CNT_W(2)) u_dut_b (
        .clk   (clk),
        .reset (reset),
        .bus   (bus_b.master)
    );

    typedef struct {
        logic       tog;
        logic       ra;
        logic       rb;
        logic       pulse;
        logic [7:0] pa;
        logic [1:0] pb;
        logic       oa;
        logic       ob;
        logic       lvl;
    } vec_t;

    vec_t vecs[$];

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    function automatic vec_t mk(input logic t, input logic ra, input logic rb,
                                input logic pulse, input logic [7:0] pa,
                                input logic [1:0] pb, input logic oa,
                                input logic ob, input logic lvl);
        vec_t v;
        v.tog = t; v.ra = ra; v.rb = rb; v.pulse = pulse;
        v.pa = pa; v.pb = pb; v.oa = oa; v.ob = ob; v.lvl = lvl;
        return v;
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic cmp(input string tag, input string what,
                       input logic [7:0] act, input logic [7:0] exp);
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s %s: got %0h, expected %0h", tag, what, act, exp);
        end
    endtask

    task automatic check_out(input string tag, input logic pulse,
                             input logic [7:0] pa, input logic [1:0] pb,
                             input logic oa, input logic ob, input logic lvl);
        n_vec++;
        cmp(tag, "pulse_a",    {7'd0, bus_a.o_pulse},    {7'd0, pulse});
        cmp(tag, "pulse_b",    {7'd0, bus_b.o_pulse},    {7'd0, pulse});
        cmp(tag, "pending_a",  bus_a.o_pending,          pa);
        cmp(tag, "pending_b",  {6'd0, bus_b.o_pending},  {6'd0, pb});
        cmp(tag, "valid_a",    {7'd0, bus_a.o_valid},    {7'd0, (pa != 8'd0)});
        cmp(tag, "valid_b",    {7'd0, bus_b.o_valid},    {7'd0, (pb != 2'd0)});
        cmp(tag, "overflow_a", {7'd0, bus_a.o_overflow}, {7'd0, oa});
        cmp(tag, "overflow_b", {7'd0, bus_b.o_overflow}, {7'd0, ob});
        cmp(tag, "level_a",    {7'd0, bus_a.o_level},    {7'd0, lvl});
        cmp(tag, "level_b",    {7'd0, bus_b.o_level},    {7'd0, lvl});
    endtask

    // Reset lands between clock edges; outputs must clear before any edge.
    task automatic async_reset_check();
        #3 reset = 1'b1;
        #1 check_out("async_reset", 1'b0, 8'd0, 2'd0, 1'b0, 1'b0, 1'b0);
        step();
        reset = 1'b0;
        step();
    endtask

    initial begin
        logic tg;
        logic l;
        int   pb0;
        int   pb1;

        n_vec = 0;
        n_bad = 0;
        tog   = 1'b1;
        rdy_a = 1'b0;
        rdy_b = 1'b0;
        reset = 1'b1;
        step();
        step();
        check_out("reset", 1'b0, 8'd0, 2'd0, 1'b0, 1'b0, 1'b0);
        reset = 1'b0;

        // Line held high across reset release: no event.
        vecs.push_back(mk(1'b1, 1'b0, 1'b0, 1'b0, 8'd0, 2'd0, 1'b0, 1'b0, 1'b0));
        for (int i = 0; i < 9; i++) begin
            vecs.push_back(mk(1'b1, 1'b0, 1'b0, 1'b0, 8'd0, 2'd0, 1'b0, 1'b0, 1'b1));
        end

`ifndef TOGGLE_DEC_GLITCH_FILTER_EN
        // Single toggle, pulse after the third edge, then one pop.
        vecs.push_back(mk(1'b0, 1'b0, 1'b0, 1'b0, 8'd0, 2'd0, 1'b0, 1'b0, 1'b1));
        vecs.push_back(mk(1'b0, 1'b0, 1'b0, 1'b0, 8'd0, 2'd0, 1'b0, 1'b0, 1'b0));
        vecs.push_back(mk(1'b0, 1'b0, 1'b0, 1'b1, 8'd1, 2'd1, 1'b0, 1'b0, 1'b0));
        vecs.push_back(mk(1'b0, 1'b0, 1'b0, 1'b0, 8'd1, 2'd1, 1'b0, 1'b0, 1'b0));
        vecs.push_back(mk(1'b0, 1'b1, 1'b1, 1'b0, 8'd0, 2'd0, 1'b0, 1'b0, 1'b0));
        vecs.push_back(mk(1'b0, 1'b0, 1'b0, 1'b0, 8'd0, 2'd0, 1'b0, 1'b0, 1'b0));

        // Five toggles four cycles apart; the 2-bit instance saturates at 3.
        for (int t = 1; t <= 5; t++) begin
            tg  = ((t % 2) == 1);
            pb0 = (t - 1 > 3) ? 3 : t - 1;
            pb1 = (t > 3) ? 3 : t;
            vecs.push_back(mk(tg, 1'b0, 1'b0, 1'b0, 8'(t - 1), 2'(pb0), 1'b0, (t - 1 >= 4), ~tg));
            vecs.push_back(mk(tg, 1'b0, 1'b0, 1'b0, 8'(t - 1), 2'(pb0), 1'b0, (t - 1 >= 4), tg));
            vecs.push_back(mk(tg, 1'b0, 1'b0, 1'b1, 8'(t),     2'(pb1), 1'b0, (t >= 4),     tg));
            vecs.push_back(mk(tg, 1'b0, 1'b0, 1'b0, 8'(t),     2'(pb1), 1'b0, (t >= 4),     tg));
        end

        // Drain one per cycle; overflow stays sticky.
        vecs.push_back(mk(1'b1, 1'b1, 1'b1, 1'b0, 8'd4, 2'd2, 1'b0, 1'b1, 1'b1));
        vecs.push_back(mk(1'b1, 1'b1, 1'b1, 1'b0, 8'd3, 2'd1, 1'b0, 1'b1, 1'b1));
        vecs.push_back(mk(1'b1, 1'b1, 1'b1, 1'b0, 8'd2, 2'd0, 1'b0, 1'b1, 1'b1));
        vecs.push_back(mk(1'b1, 1'b1, 1'b1, 1'b0, 8'd1, 2'd0, 1'b0, 1'b1, 1'b1));
        vecs.push_back(mk(1'b1, 1'b1, 1'b1, 1'b0, 8'd0, 2'd0, 1'b0, 1'b1, 1'b1));
        vecs.push_back(mk(1'b1, 1'b1, 1'b1, 1'b0, 8'd0, 2'd0, 1'b0, 1'b1, 1'b1));
        vecs.push_back(mk(1'b1, 1'b0, 1'b0, 1'b0, 8'd0, 2'd0, 1'b0, 1'b1, 1'b1));
`endif

        for (int i = 0; i < vecs.size(); i++) begin
            tog   = vecs[i].tog;
            rdy_a = vecs[i].ra;
            rdy_b = vecs[i].rb;
            step();
            check_out($sformatf("vec%0d", i), vecs[i].pulse, vecs[i].pa, vecs[i].pb,
                      vecs[i].oa, vecs[i].ob, vecs[i].lvl);
        end
        rdy_a = 1'b0;
        rdy_b = 1'b0;

`ifndef TOGGLE_DEC_GLITCH_FILTER_EN
        // Fresh start so overflow_b is clear, then fill both to 3.
        reset = 1'b1;
        step();
        reset = 1'b0;
        repeat (4) step();
        check_out("rearm", 1'b0, 8'd0, 2'd0, 1'b0, 1'b0, tog);
        for (int k = 1; k <= 3; k++) begin
            tog = ~tog;
            repeat (4) step();
            check_out($sformatf("fill%0d", k), 1'b0, 8'(k), 2'(k), 1'b0, 1'b0, tog);
        end
        rdy_a = 1'b1;
        step();
        rdy_a = 1'b0;
        check_out("pop_a", 1'b0, 8'd2, 2'd3, 1'b0, 1'b0, tog);

        // Edge and pop on the same edge: A holds at 2, full B holds at 3.
        tog = ~tog;
        step();
        step();
        rdy_a = 1'b1;
        rdy_b = 1'b1;
        step();
        rdy_a = 1'b0;
        rdy_b = 1'b0;
        check_out("edge_pop", 1'b1, 8'd2, 2'd3, 1'b0, 1'b0, tog);
        step();
        check_out("edge_pop_after", 1'b0, 8'd2, 2'd3, 1'b0, 1'b0, tog);

        // Toggles on consecutive cycles: one pulse each.
        l   = tog;
        tog = ~l;
        step();
        check_out("b2b_1", 1'b0, 8'd2, 2'd3, 1'b0, 1'b0, l);
        tog = l;
        step();
        check_out("b2b_2", 1'b0, 8'd2, 2'd3, 1'b0, 1'b0, ~l);
        tog = ~l;
        step();
        check_out("b2b_3", 1'b1, 8'd3, 2'd3, 1'b0, 1'b1, l);
        step();
        check_out("b2b_4", 1'b1, 8'd4, 2'd3, 1'b0, 1'b1, ~l);
        step();
        check_out("b2b_5", 1'b1, 8'd5, 2'd3, 1'b0, 1'b1, ~l);
        step();
        check_out("b2b_6", 1'b0, 8'd5, 2'd3, 1'b0, 1'b1, ~l);
        rdy_a = 1'b1;
        step();
        rdy_a = 1'b0;
        check_out("pre_reset", 1'b0, 8'd4, 2'd3, 1'b0, 1'b1, ~l);
`else
        // One-cycle excursion is filtered.
        tog = 1'b0;
        step();
        check_out("glitch_1", 1'b0, 8'd0, 2'd0, 1'b0, 1'b0, 1'b1);
        tog = 1'b1;
        step();
        check_out("glitch_2", 1'b0, 8'd0, 2'd0, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 4; i++) begin
            step();
            check_out($sformatf("glitch_%0d", i + 3), 1'b0, 8'd0, 2'd0, 1'b0, 1'b0, 1'b1);
        end

        // Lasting change: single pulse after the fourth edge.
        tog = 1'b0;
        step();
        check_out("hold_1", 1'b0, 8'd0, 2'd0, 1'b0, 1'b0, 1'b1);
        step();
        check_out("hold_2", 1'b0, 8'd0, 2'd0, 1'b0, 1'b0, 1'b0);
        step();
        check_out("hold_3", 1'b0, 8'd0, 2'd0, 1'b0, 1'b0, 1'b0);
        step();
        check_out("hold_4", 1'b1, 8'd1, 2'd1, 1'b0, 1'b0, 1'b0);
        step();
        check_out("hold_5", 1'b0, 8'd1, 2'd1, 1'b0, 1'b0, 1'b0);
        for (int k = 2; k <= 4; k++) begin
            tog = ~tog;
            repeat (5) step();
            check_out($sformatf("fill%0d", k), 1'b0, 8'(k), 2'((k > 3) ? 3 : k),
                      1'b0, (k >= 4), tog);
        end
`endif

        async_reset_check();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end
endmodule
`default_nettype wire
